// File: rtl/tagged_reorder_buffer_pkg.sv
// Shared definitions for tagged_reorder_buffer: depth/width derivation and the
// per-entry state encoding of the {alloc, filled} bit pair.
package tagged_reorder_buffer_pkg;

    // Encoding is {alloc, filled}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        ENTRY_FREE    = 2'b00,
        ENTRY_PENDING = 2'b10,
        ENTRY_FILLED  = 2'b11
    } entry_state_e;

    function automatic int depth_of(input int tag_w);
        return 1 << tag_w;
    endfunction

    function automatic int count_w_of(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage

// File: rtl/tagged_reorder_buffer_ram.sv
// DEPTH x DATA_W payload storage for tagged_reorder_buffer: one synchronous
// write port, one asynchronous read port.
module tagged_reorder_buffer_ram
    import tagged_reorder_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = depth_of(TAG_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the filled bits in the control logic decide
    // whether an entry's contents are meaningful, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tagged_reorder_buffer.sv
// Tagged reorder buffer: tags issued in order, responses accepted out of order
// by tag, released in order. Optional error capture: TAGGED_REORDER_BUFFER_ERR_EN.
module tagged_reorder_buffer
    import tagged_reorder_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_flush,
    input  logic              io_alloc_valid,
    output logic              io_alloc_ready,
    output logic [TAG_W-1:0]  io_alloc_tag,
    input  logic              io_enq_valid,
    input  logic [TAG_W-1:0]  io_enq_bits_tag,
    input  logic [DATA_W-1:0] io_enq_bits_data,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [TAG_W-1:0]  io_deq_tag,
    output logic [DATA_W-1:0] io_deq_data,
    output logic [TAG_W:0]    io_count
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
    ,
    output logic              io_err,
    output logic [TAG_W-1:0]  io_err_tag
`endif
);

    localparam int                DEPTH    = depth_of(TAG_W);
    localparam int                CNT_W    = count_w_of(TAG_W);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TAG_W-1:0]  PTR_ONE  = TAG_W'(1);

    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    entry_state_e     entry_q [DEPTH];

    logic alloc_fire;
    logic deq_fire;
    logic enq_legal;
    logic ram_wr_en;

    assign io_alloc_ready = (count_q != CNT_FULL);
    assign io_alloc_tag   = head_q;
    assign io_deq_valid   = (entry_q[tail_q] == ENTRY_FILLED);
    assign io_deq_tag     = tail_q;
    assign io_count       = count_q;

    assign alloc_fire = io_alloc_valid && io_alloc_ready;
    assign deq_fire   = io_deq_valid && io_deq_ready;
    // Only a pending entry may be filled; this also rejects an enq to the
    // tail while it is being dequeued, since that entry is already filled.
    assign enq_legal  = io_enq_valid && (entry_q[io_enq_bits_tag] == ENTRY_PENDING);
    assign ram_wr_en  = enq_legal && !io_flush && !reset;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || io_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= ENTRY_FREE;
            end
        end else begin
            // Alloc, enq and deq always address distinct entries when they fire
            // together: head is free, the enq target pending, the tail filled.
            if (alloc_fire) begin
                entry_q[head_q] <= ENTRY_PENDING;
                head_q          <= head_q + PTR_ONE;
            end
            if (enq_legal) begin
                entry_q[io_enq_bits_tag] <= ENTRY_FILLED;
            end
            if (deq_fire) begin
                entry_q[tail_q] <= ENTRY_FREE;
                tail_q          <= tail_q + PTR_ONE;
            end
            if (alloc_fire && !deq_fire) begin
                count_q <= count_q + CNT_ONE;
            end else if (!alloc_fire && deq_fire) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    tagged_reorder_buffer_ram #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (io_enq_bits_tag),
        .wr_data (io_enq_bits_data),
        .rd_addr (tail_q),
        .rd_data (io_deq_data)
    );

`ifdef TAGGED_REORDER_BUFFER_ERR_EN
    logic              err_q;
    logic [TAG_W-1:0]  err_tag_q;

    // Sticky: only the first illegal enq since reset/flush is recorded.
    always_ff @(posedge clk) begin
        if (reset || io_flush) begin
            err_q     <= 1'b0;
            err_tag_q <= '0;
        end else if (io_enq_valid && !enq_legal && !err_q) begin
            err_q     <= 1'b1;
            err_tag_q <= io_enq_bits_tag;
        end
    end

    assign io_err     = err_q;
    assign io_err_tag = err_tag_q;
`endif

endmodule

// File: tb/tb_tagged_reorder_buffer.sv
// Directed bench for tagged_reorder_buffer (DATA_W=32, TAG_W=2): a vector table
// for allocation/out-of-order fill, plus sequences for full, illegal enq, flush, wrap.
module tb_tagged_reorder_buffer;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_flush;
    logic              io_alloc_valid;
    logic              io_alloc_ready;
    logic [TAG_W-1:0]  io_alloc_tag;
    logic              io_enq_valid;
    logic [TAG_W-1:0]  io_enq_bits_tag;
    logic [DATA_W-1:0] io_enq_bits_data;
    logic              io_deq_valid;
    logic              io_deq_ready;
    logic [TAG_W-1:0]  io_deq_tag;
    logic [DATA_W-1:0] io_deq_data;
    logic [TAG_W:0]    io_count;
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
    logic              io_err;
    logic [TAG_W-1:0]  io_err_tag;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tagged_reorder_buffer #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .io_flush         (io_flush),
        .io_alloc_valid   (io_alloc_valid),
        .io_alloc_ready   (io_alloc_ready),
        .io_alloc_tag     (io_alloc_tag),
        .io_enq_valid     (io_enq_valid),
        .io_enq_bits_tag  (io_enq_bits_tag),
        .io_enq_bits_data (io_enq_bits_data),
        .io_deq_valid     (io_deq_valid),
        .io_deq_ready     (io_deq_ready),
        .io_deq_tag       (io_deq_tag),
        .io_deq_data      (io_deq_data),
        .io_count         (io_count)
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
        ,
        .io_err           (io_err),
        .io_err_tag       (io_err_tag)
`endif
    );

    typedef struct {
        logic              alloc_valid;
        logic              enq_valid;
        logic [TAG_W-1:0]  enq_tag;
        logic [DATA_W-1:0] enq_data;
        logic              deq_ready;
        logic              exp_alloc_ready;
        logic [TAG_W-1:0]  exp_alloc_tag;
        logic              exp_deq_valid;
        logic [TAG_W-1:0]  exp_deq_tag;
        logic [DATA_W-1:0] exp_deq_data;
        logic [TAG_W:0]    exp_count;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs mid-cycle; outputs sampled afterwards reflect
    // the state before the next rising edge.
    task automatic set_in(input logic av, input logic ev, input logic [TAG_W-1:0] et,
                          input logic [DATA_W-1:0] ed, input logic dr, input logic fl);
        @(negedge clk);
        io_alloc_valid   = av;
        io_enq_valid     = ev;
        io_enq_bits_tag  = et;
        io_enq_bits_data = ed;
        io_deq_ready     = dr;
        io_flush         = fl;
        #1;
    endtask

    initial begin
        // alloc 4x, then out-of-order fill 2,0,3,1 drained in order 0,1,2,3
        //          av  ev  et  ed      dr   rdy atag dv dtag ddata   cnt
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0, 3'd1};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 3'd2};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 32'h0, 3'd3};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 3'd4};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'hC, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 3'd4};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 32'hA, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 3'd4};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 32'hD, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 32'hA, 3'd4};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'hB, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 32'h0, 3'd3};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 32'hB, 3'd3};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 32'hC, 3'd2};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd3, 32'hD, 3'd1};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 3'd0};

        reset            = 1'b1;
        io_flush         = 1'b0;
        io_alloc_valid   = 1'b0;
        io_enq_valid     = 1'b0;
        io_enq_bits_tag  = '0;
        io_enq_bits_data = '0;
        io_deq_ready     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_alloc_ready", 64'(io_alloc_ready), 64'd1);
        check("rst_alloc_tag",   64'(io_alloc_tag),   64'd0);
        check("rst_deq_valid",   64'(io_deq_valid),   64'd0);
        check("rst_deq_tag",     64'(io_deq_tag),     64'd0);
        check("rst_count",       64'(io_count),       64'd0);
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
        check("rst_err",         64'(io_err),         64'd0);
`endif

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].alloc_valid, vecs[i].enq_valid, vecs[i].enq_tag,
                   vecs[i].enq_data, vecs[i].deq_ready, 1'b0);
            check($sformatf("v%0d_alloc_ready", i), 64'(io_alloc_ready), 64'(vecs[i].exp_alloc_ready));
            check($sformatf("v%0d_alloc_tag", i),   64'(io_alloc_tag),   64'(vecs[i].exp_alloc_tag));
            check($sformatf("v%0d_deq_valid", i),   64'(io_deq_valid),   64'(vecs[i].exp_deq_valid));
            check($sformatf("v%0d_deq_tag", i),     64'(io_deq_tag),     64'(vecs[i].exp_deq_tag));
            check($sformatf("v%0d_count", i),       64'(io_count),       64'(vecs[i].exp_count));
            if (vecs[i].exp_deq_valid) begin
                check($sformatf("v%0d_deq_data", i), 64'(io_deq_data), 64'(vecs[i].exp_deq_data));
            end
        end

        // Full buffer: alloc and deq together -> only deq; freed slot next cycle.
        repeat (4) set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 2'd0, 32'h11, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        check("full_deq_valid",   64'(io_deq_valid),   64'd1);
        check("full_deq_data",    64'(io_deq_data),    64'h11);
        check("full_alloc_ready", 64'(io_alloc_ready), 64'd0);
        check("full_count",       64'(io_count),       64'd4);
        set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("freed_alloc_ready", 64'(io_alloc_ready), 64'd1);
        check("freed_alloc_tag",   64'(io_alloc_tag),   64'd0);
        check("freed_count",       64'(io_count),       64'd3);
        check("freed_deq_tag",     64'(io_deq_tag),     64'd1);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("refull_count",       64'(io_count),       64'd4);
        check("refull_alloc_ready", 64'(io_alloc_ready), 64'd0);
        check("refull_alloc_tag",   64'(io_alloc_tag),   64'd1);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("flush1_count",     64'(io_count),     64'd0);
        check("flush1_alloc_tag", 64'(io_alloc_tag), 64'd0);

        // Illegal enqs: unallocated tag 3, then a second fill of tag 0.
        set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 2'd3, 32'hEE, 1'b0, 1'b0);
        check("ill_pre_count", 64'(io_count), 64'd1);
        set_in(1'b0, 1'b1, 2'd0, 32'h22, 1'b0, 1'b0);
        check("ill_unalloc_count",     64'(io_count),     64'd1);
        check("ill_unalloc_deq_valid", 64'(io_deq_valid), 64'd0);
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
        check("ill_err",     64'(io_err),     64'd1);
        check("ill_err_tag", 64'(io_err_tag), 64'd3);
`endif
        set_in(1'b0, 1'b1, 2'd0, 32'h33, 1'b0, 1'b0);
        check("refill_deq_valid", 64'(io_deq_valid), 64'd1);
        check("refill_deq_data",  64'(io_deq_data),  64'h22);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        check("refill_keep_data", 64'(io_deq_data), 64'h22);
        check("refill_count",     64'(io_count),    64'd1);
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
        check("ill_err_tag_sticky", 64'(io_err_tag), 64'd3);
`endif

        // Flush with 3 allocated (tags 1..3), two filled, plus a concurrent enq.
        repeat (3) set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 2'd1, 32'h41, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 2'd2, 32'h42, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 2'd3, 32'h43, 1'b1, 1'b1);
        check("preflush_count",     64'(io_count),     64'd3);
        check("preflush_deq_valid", 64'(io_deq_valid), 64'd1);
        check("preflush_deq_tag",   64'(io_deq_tag),   64'd1);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("flush_count",       64'(io_count),       64'd0);
        check("flush_deq_valid",   64'(io_deq_valid),   64'd0);
        check("flush_alloc_tag",   64'(io_alloc_tag),   64'd0);
        check("flush_alloc_ready", 64'(io_alloc_ready), 64'd1);
        check("flush_deq_tag",     64'(io_deq_tag),     64'd0);
`ifdef TAGGED_REORDER_BUFFER_ERR_EN
        check("flush_err", 64'(io_err), 64'd0);
`endif

        // Pointer wrap: 10 alloc/enq/deq rounds.
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
            check($sformatf("wrap%0d_alloc_tag", i), 64'(io_alloc_tag), 64'(i % 4));
            set_in(1'b0, 1'b1, TAG_W'(i % 4), 32'(32'h100 + i), 1'b0, 1'b0);
            check($sformatf("wrap%0d_count", i), 64'(io_count), 64'd1);
            set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
            check($sformatf("wrap%0d_deq_tag", i),  64'(io_deq_tag),  64'(i % 4));
            check($sformatf("wrap%0d_deq_data", i), 64'(io_deq_data), 64'(32'h100 + i));
            check($sformatf("wrap%0d_deq_valid", i), 64'(io_deq_valid), 64'd1);
        end

        // Alloc + enq + deq on distinct tags in one cycle (head=tail=2 here).
        set_in(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 2'd2, 32'h77, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 2'd3, 32'h88, 1'b1, 1'b0);
        check("tri_pre_deq_data", 64'(io_deq_data),  64'h77);
        check("tri_pre_count",    64'(io_count),     64'd2);
        check("tri_pre_alloc_tag", 64'(io_alloc_tag), 64'd0);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("tri_count",     64'(io_count),     64'd2);
        check("tri_deq_valid", 64'(io_deq_valid), 64'd1);
        check("tri_deq_tag",   64'(io_deq_tag),   64'd3);
        check("tri_deq_data",  64'(io_deq_data),  64'h88);
        check("tri_alloc_tag", 64'(io_alloc_tag), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
